kurm_instr_sequencer: RTL and testbench

Fetch/issue end of the KURM opcode interface. It drives the 4-bit opcode that kurm_controller decodes. It holds the PC, fetches 16-bit instructions from instruction memory over a req/ack handshake, and issues each legal instruction with a valid/ready handshake. It resolves JUMP itself and resolves BNE from an ALU condition return, then computes the next PC.

---
 rtl/kurm_pkg.sv | 40 ++++
 rtl/kurm_next_pc.sv | 47 ++++
 rtl/kurm_instr_sequencer.sv | 143 ++++++++++++++
 tb/tb_kurm_instr_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kurm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kurm_pkg : shared KURM opcodes, sequencer state and next-PC select encodings
// Rev 1.0
// ----------------------------------------------------------------------------
package kurm_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1110;
  localparam logic [3:0] OP_JUMP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_RESOLVE = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    NPC_INC      = 2'd0,
    NPC_JUMP     = 2'd1,
    NPC_BR_TAKEN = 2'd2
  } npc_sel_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_LW, OP_SW, OP_BNE, OP_JUMP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/kurm_next_pc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kurm_next_pc : combinational next-PC (increment, absolute jump, taken branch)
// Rev 1.0
// ----------------------------------------------------------------------------
module kurm_next_pc
  import kurm_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
)(
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  npc_sel_e           i_sel,
  output logic [PC_W-1:0]    o_next_pc
);

  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_inc;
  logic            w_unused_instr;

  // Branch offset is instr[7:0], sign-extended or truncated to the PC width.
  generate
    if (PC_W > 8) begin : g_sext_wide
      assign w_off = {{(PC_W-8){i_instr[7]}}, i_instr[7:0]};
    end else if (PC_W == 8) begin : g_sext_exact
      assign w_off = i_instr[7:0];
    end else begin : g_sext_trunc
      assign w_off = i_instr[PC_W-1:0];
    end
  endgenerate

  assign w_inc = i_pc + PC_W'(1);

  always_comb begin
    o_next_pc = w_inc;
    case (i_sel)
      NPC_JUMP:     o_next_pc = i_instr[PC_W-1:0];
      NPC_BR_TAKEN: o_next_pc = w_inc + w_off;
      default:      o_next_pc = w_inc;
    endcase
  end

  assign w_unused_instr = ^i_instr;

endmodule
`default_nettype wire

// File: rtl/kurm_instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kurm_instr_sequencer : PC, instruction fetch (req/ack), issue (valid/ready)
// Rev 1.0
// ----------------------------------------------------------------------------
module kurm_instr_sequencer
  import kurm_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [3:0]         opcode,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    issue_pc,
  input  logic               cond_valid,
  input  logic               cond_ne,
  output logic               illegal
);

  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_issue_pc;
  logic               r_illegal;

  npc_sel_e           w_sel;
  logic               w_pc_load;
  logic               w_capture;
  logic               w_illegal_nxt;
  logic               w_fetch_ack;
  logic [3:0]         w_fetch_op;
  logic [3:0]         w_issue_op;
  logic [PC_W-1:0]    w_next_pc;

  assign w_fetch_op  = imem_rdata[INSTR_W-1 -: 4];
  assign w_issue_op  = r_instr[INSTR_W-1 -: 4];
  // The illegal-pulse cycle stays in FETCH with req low, so any ack then is stray.
  assign w_fetch_ack = imem_ack && !r_illegal;

  kurm_next_pc #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_next_pc (
    .i_pc      (r_pc),
    .i_instr   (r_instr),
    .i_sel     (w_sel),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel         = NPC_INC;
    w_pc_load     = 1'b0;
    w_capture     = 1'b0;
    w_illegal_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_fetch_ack) begin
          if (is_legal_op(w_fetch_op)) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_illegal_nxt = 1'b1;
            w_pc_load     = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          if (w_issue_op == OP_JUMP) begin
            w_sel       = NPC_JUMP;
            w_pc_load   = 1'b1;
            w_state_nxt = ST_FETCH;
          end else if (w_issue_op == OP_BNE) begin
            w_state_nxt = ST_RESOLVE;
          end else begin
            w_pc_load   = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_RESOLVE: begin
        if (cond_valid) begin
          w_sel       = cond_ne ? NPC_BR_TAKEN : NPC_INC;
          w_pc_load   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_issue_pc <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= w_illegal_nxt;
      if (w_pc_load) begin
        r_pc <= w_next_pc;
      end
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_issue_pc <= r_pc;
      end
    end
  end

  assign imem_req    = (r_state == ST_FETCH) && !r_illegal;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign opcode      = w_issue_op;
  assign instr       = r_instr;
  assign issue_pc    = r_issue_pc;
  assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_kurm_instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_kurm_instr_sequencer : program-level model plus directed program scenarios
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_kurm_instr_sequencer;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode;
  logic [15:0] instr;
  logic [7:0]  issue_pc;
  logic        cond_valid;
  logic        cond_ne;
  logic        illegal;

  kurm_instr_sequencer #(
    .PC_W     (8),
    .INSTR_W  (16),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .instr       (instr),
    .issue_pc    (issue_pc),
    .cond_valid  (cond_valid),
    .cond_ne     (cond_ne),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Instruction memory and responder knobs
  logic [15:0] mem [256];
  int ack_delay   = 0;
  int ready_stall = 0;
  int spur_ack    = 0;
  int cond_en     = 0;
  int cond_ne_k   = 0;

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
  endtask

  initial begin
    int wcnt;
    int scnt;
    wcnt = 0;
    scnt = 0;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    instr_ready = 1'b0;
    cond_valid  = 1'b0;
    cond_ne     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
        imem_ack   = (wcnt == ack_delay);
        imem_rdata = imem_ack ? mem[imem_addr] : 16'h3BAD;
        wcnt++;
      end else begin
        wcnt       = 0;
        imem_ack   = (spur_ack != 0);
        imem_rdata = 16'h2555;
      end
      if (instr_valid === 1'b1) begin
        instr_ready = (scnt >= ready_stall);
        scnt++;
      end else begin
        scnt        = 0;
        instr_ready = 1'b1;
      end
      cond_valid = (cond_en != 0);
      cond_ne    = (cond_ne_k != 0);
    end
  end

  // Observation logs of what the DUT actually did
  int cyc = 0;
  int first_req = -1;
  int rel_cyc = -1;
  int fq[$];
  int fq_cyc[$];
  int tq_pc[$];
  int tq_op[$];
  int tq_cyc[$];
  int ill_cyc[$];

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Program-level model: tracks the architectural PC and which handshake is owed
  logic        m_active = 1'b0;
  logic        m_rst_chk = 1'b0;
  logic        m_idle = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_await = 1'b0;
  logic        m_ill = 1'b0;
  logic [7:0]  m_pc = 8'h00;
  logic [7:0]  m_ipc = 8'h00;
  logic [15:0] m_instr = 16'h0000;

  initial begin
    logic       exp_req;
    logic       nxt_ill;
    logic [3:0] op;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_active) begin
        if (m_rst_chk) begin
          chk("rst_imem_req", 32'(imem_req), 32'(1'b0));
          chk("rst_instr_valid", 32'(instr_valid), 32'(1'b0));
          chk("rst_illegal", 32'(illegal), 32'(1'b0));
          chk("rst_opcode", 32'(opcode), 32'(4'h0));
          chk("rst_instr", 32'(instr), 32'(16'h0000));
          chk("rst_issue_pc", 32'(issue_pc), 32'(8'h00));
          chk("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC));
        end else begin
          exp_req = !m_idle && !m_pend && !m_await && !m_ill;
          chk("imem_req", 32'(imem_req), 32'(exp_req));
          if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
          chk("instr_valid", 32'(instr_valid), 32'(m_pend));
          if (m_pend) begin
            chk("instr", 32'(instr), 32'(m_instr));
            chk("opcode", 32'(opcode), 32'(m_instr[15:12]));
            chk("issue_pc", 32'(issue_pc), 32'(m_ipc));
          end
          chk("illegal", 32'(illegal), 32'(m_ill));
        end
      end

      if (m_active && rst_n === 1'b1) begin
        if (m_rst_chk) rel_cyc = cyc;
        if (imem_req === 1'b1 && first_req < 0) first_req = cyc;
        if (imem_req === 1'b1 && imem_ack === 1'b1) begin
          fq.push_back(int'(imem_addr));
          fq_cyc.push_back(cyc);
        end
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
          tq_pc.push_back(int'(issue_pc));
          tq_op.push_back(int'(opcode));
          tq_cyc.push_back(cyc);
        end
        if (illegal === 1'b1) ill_cyc.push_back(cyc);
      end

      if (rst_n !== 1'b1) begin
        m_active  = 1'b1;
        m_rst_chk = 1'b1;
        m_idle    = 1'b1;
        m_pend    = 1'b0;
        m_await   = 1'b0;
        m_ill     = 1'b0;
        m_pc      = RESET_PC;
      end else if (m_active) begin
        nxt_ill = 1'b0;
        if (m_idle) begin
          m_idle = 1'b0;
        end else if (m_ill) begin
          nxt_ill = 1'b0;
        end else if (m_await) begin
          if (cond_valid) begin
            m_pc    = m_pc + 8'd1 + (cond_ne ? m_instr[7:0] : 8'd0);
            m_await = 1'b0;
          end
        end else if (m_pend) begin
          if (instr_ready) begin
            op = m_instr[15:12];
            if (op == 4'hF) m_pc = m_instr[7:0];
            else if (op == 4'hE) m_await = 1'b1;
            else m_pc = m_pc + 8'd1;
            m_pend = 1'b0;
          end
        end else if (imem_ack) begin
          if (imem_rdata[15:12] inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE, 4'hF}) begin
            m_pend  = 1'b1;
            m_instr = imem_rdata;
            m_ipc   = m_pc;
          end else begin
            nxt_ill = 1'b1;
            m_pc    = m_pc + 8'd1;
          end
        end
        m_ill     = nxt_ill;
        m_rst_chk = 1'b0;
      end
    end
  end

  task automatic reset_assert();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fq.delete();
    fq_cyc.delete();
    tq_pc.delete();
    tq_op.delete();
    tq_cyc.delete();
    ill_cyc.delete();
    first_req = -1;
    rel_cyc   = -1;
  endtask

  task automatic reset_dut();
    reset_assert();
    reset_release();
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    fill_mem();
    repeat (2) @(posedge clk);

    // Straight-line ADD, SUB, LW with ack and ready immediate
    mem[0] = 16'h2123;
    mem[1] = 16'h6456;
    mem[2] = 16'h8789;
    reset_dut();
    run(10);
    chk("A_first_req_latency", first_req - rel_cyc, 1);
    chk("A_op0", at(tq_op, 0), 32'h2);
    chk("A_op1", at(tq_op, 1), 32'h6);
    chk("A_op2", at(tq_op, 2), 32'h8);
    chk("A_pc0", at(tq_pc, 0), 0);
    chk("A_pc1", at(tq_pc, 1), 1);
    chk("A_pc2", at(tq_pc, 2), 2);
    chk("A_issue_gap01", at(tq_cyc, 1) - at(tq_cyc, 0), 2);
    chk("A_issue_gap12", at(tq_cyc, 2) - at(tq_cyc, 1), 2);

    // JUMP to 0x20, BNE with offset -4, taken and not taken; cond held high throughout
    fill_mem();
    mem[5]    = 16'hF020;
    mem[8'h20] = 16'hE0FC;
    cond_en   = 1;
    cond_ne_k = 1;
    reset_dut();
    run(24);
    chk("B_jump_target", at(fq, 6), 32'h20);
    chk("B_bne_issued", at(tq_op, 6), 32'hE);
    chk("B_taken_target", at(fq, 7), 32'h1D);
    cond_ne_k = 0;
    reset_dut();
    run(24);
    chk("B_not_taken_target", at(fq, 7), 32'h21);
    cond_en = 0;

    // Backpressure on SW issue
    fill_mem();
    mem[0] = 16'hA123;
    ready_stall = 4;
    reset_dut();
    run(14);
    chk("C_sw_op", at(tq_op, 0), 32'hA);
    chk("C_sw_pc", at(tq_pc, 0), 0);
    chk("C_hold_cycles", at(tq_cyc, 0) - at(fq_cyc, 0), 5);
    chk("C_next_pc", at(tq_pc, 1), 1);
    ready_stall = 0;

    // Delayed fetch acknowledge
    fill_mem();
    ack_delay = 3;
    reset_dut();
    run(16);
    chk("D_ack_wait", at(fq_cyc, 0) - first_req, 3);
    chk("D_fetch0", at(fq, 0), 0);
    chk("D_fetch1", at(fq, 1), 1);
    ack_delay = 0;

    // Illegal opcode at 0xFF wraps to 0x00; stray acks and cond pulses ignored
    fill_mem();
    mem[0]     = 16'hF0FF;
    mem[8'hFF] = 16'h3000;
    spur_ack   = 1;
    cond_en    = 1;
    cond_ne_k  = 1;
    reset_dut();
    run(10);
    chk("E_fetch0", at(fq, 0), 32'h00);
    chk("E_fetch_ff", at(fq, 1), 32'hFF);
    chk("E_wrap_fetch", at(fq, 2), 32'h00);
    chk("E_pulse_after_ack", at(ill_cyc, 0) - at(fq_cyc, 1), 1);
    chk("E_refetch_after_pulse", at(fq_cyc, 2) - at(ill_cyc, 0), 1);
    chk("E_ff_not_issued", at(tq_pc, 1), 0);
    spur_ack = 0;
    cond_en  = 0;

    // Reset during RESOLVE, then during a pending fetch
    fill_mem();
    mem[0] = 16'hE005;
    mem[6] = 16'hF000;
    reset_dut();
    for (int i = 0; i < 40 && tq_op.size() == 0; i++) @(posedge clk);
    #1;
    chk("F_bne_issued_count", tq_op.size(), 1);
    run(3);
    reset_assert();
    cond_en   = 1;
    cond_ne_k = 1;
    reset_release();
    run(12);
    chk("F_restart_fetch", at(fq, 0), 32'h00);
    chk("F_branch_after_restart", at(fq, 1), 32'h06);
    reset_assert();
    ack_delay = 6;
    reset_release();
    run(3);
    chk("F_fetch_pending", fq.size(), 0);
    reset_assert();
    ack_delay = 0;
    reset_release();
    run(6);
    chk("F_restart_after_abort", at(fq, 0), 32'h00);
    chk("F_restart_ack_now", at(fq_cyc, 0) - first_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
